control_multiciclo: RTL and testbench

- Multicycle control FSM for the microprocessor datapath.
- Sequences fetch, decode, execute, memory access and writeback for each instruction.
- Drives the ImnSrc select of the sign extender, plus the ALU, memory, PC and register-file strobes.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes. Memory accesses use a req/ready handshake.

---
 rtl/control_multiciclo.sv | 174 +++++++++++++++++
 tb/tb_control_multiciclo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// Multicycle control FSM: fetch / decode / execute / memory / writeback
// sequencing for the datapath, with a req/ready memory handshake.
// Optional retired-instruction counter enabled by CTRL_INSTR_COUNT_EN.
module control_multiciclo #(
  parameter int OPC_W      = 7,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPC_W-1:0]      opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic                  imm_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [1:0]            result_src,
  output logic                  illegal,
  output logic [3:0]            state_dbg
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0]           instr_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMREAD = 4'd4,
    S_MEMWB   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_LUI_WB  = 4'd9,
    S_HALT    = 4'd10
  } state_t;

  localparam logic [OPC_W-1:0] OP_LW  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OP_R   = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OP_I   = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OP_LUI = OPC_W'(7'b0110111);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b101);

  state_t                  r_state;
  state_t                  w_next;
  logic [ALU_CTRL_W-1:0]   w_alu_dec;
  logic                    w_funct_ok;

  // ALU operation from funct3; sub only for R-type with funct7b5 set
  always_comb begin
    w_alu_dec  = ALU_ADD;
    w_funct_ok = 1'b1;
    case (funct3)
      3'b000:  w_alu_dec = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b110:  w_alu_dec = ALU_OR;
      3'b111:  w_alu_dec = ALU_AND;
      default: w_funct_ok = 1'b0;
    endcase
  end

  // State register; reset lands in IDLE immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and Moore outputs (FETCH strobes qualified by mem_ready)
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    result_src = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        imm_src = (opcode == OP_LUI);
        if      (opcode == OP_LW)  w_next = S_MEMADR;
        else if (opcode == OP_R)   w_next = w_funct_ok ? S_EXEC_R : S_HALT;
        else if (opcode == OP_I)   w_next = w_funct_ok ? S_EXEC_I : S_HALT;
        else if (opcode == OP_LUI) w_next = S_LUI_WB;
        else                       w_next = S_HALT;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_ctrl  = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_LUI_WB: begin
        imm_src    = 1'b1;
        result_src = 2'b11;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
        w_next  = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state_dbg = r_state;

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] r_instr_count;

  // Count retired instructions: every writeback state exits after one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_instr_count <= '0;
    else if (r_state == S_MEMWB || r_state == S_ALUWB || r_state == S_LUI_WB)
      r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo: stimulus pushes the hand-computed
// per-cycle output vector, a negedge monitor pops and compares.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       mem_ready;
  logic       mem_req, adr_src, ir_write, pc_write, reg_write, imm_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_dbg;
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .mem_ready(mem_ready), .mem_req(mem_req),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src),
    .illegal(illegal), .state_dbg(state_dbg)
`ifdef CTRL_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, adr, irw, pcw, rw, imm;
    logic [1:0] asa, asb;
    logic [2:0] actl;
    logic [1:0] rs;
    logic       ill;
  } vec_t;

  vec_t  q[$];
  string nq[$];
  int    tests = 0;
  int    fails = 0;

  function automatic vec_t mk(input logic [3:0] st, input logic mreq, adr,
                              irw, pcw, rw, imm, input logic [1:0] asa, asb,
                              input logic [2:0] actl, input logic [1:0] rs,
                              input logic ill);
    vec_t v;
    v = {st, mreq, adr, irw, pcw, rw, imm, asa, asb, actl, rs, ill};
    return v;
  endfunction

  vec_t V_IDLE, V_FR, V_FW, V_DEC0, V_DEC1, V_HALT, V_ALUWB;

  // Monitor: compare the live outputs with the oldest pending expectation
  vec_t  m_act, m_exp;
  string m_nm;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_exp = q.pop_front();
      m_nm  = nq.pop_front();
      m_act = {state_dbg, mem_req, adr_src, ir_write, pc_write, reg_write,
               imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src, illegal};
      tests++;
      if (m_act !== m_exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h (st got %0d exp %0d)",
                 m_nm, m_act, m_exp, m_act.st, m_exp.st);
      end
    end
  end

  task automatic step(input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic mr, input vec_t ex,
                      input string nm);
    @(posedge clk); #1;
    opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = mr;
    q.push_back(ex); nq.push_back(nm);
  endtask

  // Asynchronous reset mid-cycle: outputs must drop before any clock edge
  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.push_back(V_IDLE); nq.push_back(nm);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_alu(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [3:0] ex_st,
                         input logic [1:0] ex_asb, input logic [2:0] ex_actl,
                         input string nm);
    step(op, f3, f7, 1'b1, V_FR,   {nm, " fetch"});
    step(op, f3, f7, 1'b0, V_DEC0, {nm, " decode"});
    step(op, f3, f7, 1'b1, mk(ex_st, 0, 0, 0, 0, 0, 0, 2'b10, ex_asb, ex_actl, 2'b00, 0),
         {nm, " exec"});
    step(op, f3, f7, 1'b0, V_ALUWB, {nm, " aluwb"});
  endtask

  initial begin
    V_IDLE  = mk(4'd0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    V_FR    = mk(4'd1,  1, 0, 1, 1, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 0);
    V_FW    = mk(4'd1,  1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 0);
    V_DEC0  = mk(4'd2,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    V_DEC1  = mk(4'd2,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    V_HALT  = mk(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1);
    V_ALUWB = mk(4'd8,  0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0);

    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0; mem_ready = 1'b0;
    #1;
    q.push_back(V_IDLE); nq.push_back("reset idle");
    #11 rst_n = 1'b1;

    // ALU instructions: (opcode, funct3, funct7b5) -> exec state, srcB, alu_ctrl
    run_alu(7'b0110011, 3'b000, 1'b0, 4'd6, 2'b00, 3'b000, "add");
    run_alu(7'b0110011, 3'b000, 1'b1, 4'd6, 2'b00, 3'b001, "sub");
    run_alu(7'b0010011, 3'b000, 1'b1, 4'd7, 2'b01, 3'b000, "addi f7b5");
    run_alu(7'b0110011, 3'b110, 1'b0, 4'd6, 2'b00, 3'b011, "or");
    run_alu(7'b0010011, 3'b111, 1'b0, 4'd7, 2'b01, 3'b010, "andi");
    run_alu(7'b0010011, 3'b010, 1'b1, 4'd7, 2'b01, 3'b101, "slti");
    run_alu(7'b0110011, 3'b010, 1'b1, 4'd6, 2'b00, 3'b101, "slt f7b5");

    // lw with one fetch wait and three memory wait cycles
    step(7'b0000011, 3'b010, 1'b0, 1'b0, V_FW,   "lw fetch wait");
    step(7'b0000011, 3'b010, 1'b0, 1'b1, V_FR,   "lw fetch");
    step(7'b0000011, 3'b010, 1'b0, 1'b1, V_DEC0, "lw decode");
    step(7'b0000011, 3'b010, 1'b0, 1'b1,
         mk(4'd3, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 0), "lw memadr");
    for (int i = 0; i < 4; i++)
      step(7'b0000011, 3'b010, 1'b0, (i == 3),
           mk(4'd4, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0), "lw memread");
    step(7'b0000011, 3'b010, 1'b0, 1'b1,
         mk(4'd5, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0), "lw memwb");

    // Reset while in MEMREAD with mem_req high
    step(7'b0000011, 3'b010, 1'b0, 1'b1, V_FR,   "rst fetch");
    step(7'b0000011, 3'b010, 1'b0, 1'b0, V_DEC0, "rst decode");
    step(7'b0000011, 3'b010, 1'b0, 1'b0,
         mk(4'd3, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 0), "rst memadr");
    step(7'b0000011, 3'b010, 1'b0, 1'b0,
         mk(4'd4, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0), "rst memread");
    do_reset("async reset in memread");

    // lui; its trailing fetch carries the illegal opcode for the next test
    step(7'b0110111, 3'b000, 1'b0, 1'b1, V_FR,   "lui fetch after reset");
    step(7'b0110111, 3'b000, 1'b0, 1'b0, V_DEC1, "lui decode");
    step(7'b0110111, 3'b000, 1'b0, 1'b1,
         mk(4'd9, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000, 2'b11, 0), "lui wb");
    step(7'b1111111, 3'b000, 1'b0, 1'b1, V_FR,   "fetch after lui");

    // Illegal opcode -> HALT held across clocks regardless of mem_ready
    step(7'b1111111, 3'b000, 1'b0, 1'b1, V_DEC0, "illegal op decode");
    for (int i = 0; i < 11; i++)
      step(7'b0110011, 3'b000, 1'b0, i[0], V_HALT, "halt op");
`ifdef CTRL_INSTR_COUNT_EN
    @(negedge clk); #1;
    tests++;
    if (instr_count !== 32'd1) begin
      fails++;
      $display("FAIL instr_count in halt: got %0d expected 1", instr_count);
    end
`endif
    do_reset("reset from halt");

    // Unsupported funct3 on R-type -> HALT
    step(7'b0110011, 3'b001, 1'b0, 1'b1, V_FR,   "bad funct fetch");
    step(7'b0110011, 3'b001, 1'b0, 1'b0, V_DEC0, "bad funct decode");
    for (int i = 0; i < 3; i++)
      step(7'b0110011, 3'b001, 1'b0, 1'b1, V_HALT, "halt funct");

    @(negedge clk); #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
